// File: rtl/clk_div_multi_if.sv
// Bundle between a controller and clk_div_multi: run enables and the
// configuration write port go in; divided clocks, period ticks and write errors come out.
interface clk_div_multi_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 16
);
   logic [NUM_CH-1:0] ch_en;
   logic              cfg_we;
   logic [3:0]        cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_lo;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic              cfg_err;

   modport master (
      output ch_en, cfg_we, cfg_ch, cfg_div, cfg_lo,
      input  clk_out, tick, cfg_err
   );

   modport slave (
      input  ch_en, cfg_we, cfg_ch, cfg_div, cfg_lo,
      output clk_out, tick, cfg_err
   );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; each channel has its own period/low length,
// and new settings are held pending until the running period wraps so no period is cut short.
module clk_div_multi #(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = 50000,
   parameter int DEF_LO  = 25000
) (
   input  logic           sys_clk,
   input  logic           rst,
   clk_div_multi_if.slave bus
);
   localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] DEF_LO_V  = DIV_W'(DEF_LO);

   logic cfg_ok;
   logic cfg_err_reg;

   always_comb begin
      cfg_ok = (32'(bus.cfg_ch) < NUM_CH)
            && (bus.cfg_div >= DIV_W'(2))
            && (bus.cfg_lo != '0)
            && (bus.cfg_lo < bus.cfg_div);
   end

   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         cfg_err_reg <= 1'b0;
      end else begin
         cfg_err_reg <= bus.cfg_we && !cfg_ok;
      end
   end

   assign bus.cfg_err = cfg_err_reg;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic [DIV_W-1:0] act_div_reg, act_div_next;
      logic [DIV_W-1:0] act_lo_reg, act_lo_next;
      logic [DIV_W-1:0] pend_div_reg, pend_div_next;
      logic [DIV_W-1:0] pend_lo_reg, pend_lo_next;
      logic             pend_v_reg, pend_v_next;
      logic             clk_out_reg;
      logic             tick_reg;
      logic             wr_hit;
      logic             wrap;

      assign wr_hit = bus.cfg_we && cfg_ok && (bus.cfg_ch == 4'(gi));
      // act_div is never below 2, so the subtraction cannot underflow
      assign wrap   = (cnt_reg >= (act_div_reg - DIV_W'(1)));

      always_comb begin
         cnt_next      = cnt_reg;
         act_div_next  = act_div_reg;
         act_lo_next   = act_lo_reg;
         pend_div_next = pend_div_reg;
         pend_lo_next  = pend_lo_reg;
         pend_v_next   = pend_v_reg;
         if (!bus.ch_en[gi]) begin
            cnt_next = '0;
            if (wr_hit) begin
               act_div_next = bus.cfg_div;
               act_lo_next  = bus.cfg_lo;
               pend_v_next  = 1'b0;
            end
         end else if (wrap) begin
            cnt_next = '0;
            // a write landing on the wrap edge beats an older pending value
            if (wr_hit) begin
               act_div_next = bus.cfg_div;
               act_lo_next  = bus.cfg_lo;
               pend_v_next  = 1'b0;
            end else if (pend_v_reg) begin
               act_div_next = pend_div_reg;
               act_lo_next  = pend_lo_reg;
               pend_v_next  = 1'b0;
            end
         end else begin
            cnt_next = cnt_reg + DIV_W'(1);
            if (wr_hit) begin
               pend_div_next = bus.cfg_div;
               pend_lo_next  = bus.cfg_lo;
               pend_v_next   = 1'b1;
            end
         end
      end

      always_ff @(posedge sys_clk) begin
         if (!rst) begin
            cnt_reg      <= '0;
            act_div_reg  <= DEF_DIV_V;
            act_lo_reg   <= DEF_LO_V;
            pend_div_reg <= DEF_DIV_V;
            pend_lo_reg  <= DEF_LO_V;
            pend_v_reg   <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
         end else begin
            cnt_reg      <= cnt_next;
            act_div_reg  <= act_div_next;
            act_lo_reg   <= act_lo_next;
            pend_div_reg <= pend_div_next;
            pend_lo_reg  <= pend_lo_next;
            pend_v_reg   <= pend_v_next;
            // outputs track the counter value that becomes current at this edge
            clk_out_reg  <= bus.ch_en[gi] && (cnt_next >= act_lo_next);
            tick_reg     <= bus.ch_en[gi] && (cnt_next == '0);
         end
      end

      assign bus.clk_out[gi] = clk_out_reg;
      assign bus.tick[gi]    = tick_reg;
   end
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the channel rules.
module tb_clk_div_multi;
   logic sys_clk;
   logic rst;

   clk_div_multi_if #(.NUM_CH(4), .DIV_W(8)) bus ();

   clk_div_multi #(
      .NUM_CH (4),
      .DIV_W  (8),
      .DEF_DIV(10),
      .DEF_LO (5)
   ) dut (
      .sys_clk(sys_clk),
      .rst    (rst),
      .bus    (bus.slave)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;

   // behavioural model: position in period, period settings, pending settings
   int m_cnt[4];
   int m_div[4];
   int m_lo[4];
   int m_pdiv[4];
   int m_plo[4];
   bit m_pv[4];
   bit m_en_last[4];
   bit m_err;

   function automatic logic [3:0] exp_clk();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_en_last[i] && (m_cnt[i] >= m_lo[i]);
      return v;
   endfunction

   function automatic logic [3:0] exp_tick();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_en_last[i] && (m_cnt[i] == 0);
      return v;
   endfunction

   task automatic step();
      logic [3:0] en;
      logic we, r;
      int ch, dv, lo;
      bit ok, w;
      en = bus.ch_en;
      we = bus.cfg_we;
      r  = rst;
      ch = int'(bus.cfg_ch);
      dv = int'(bus.cfg_div);
      lo = int'(bus.cfg_lo);
      @(posedge sys_clk);
      ok = (ch < 4) && (dv >= 2) && (lo >= 1) && (lo < dv);
      if (!r) begin
         m_err = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;  m_div[i] = 10; m_lo[i] = 5;
            m_pdiv[i] = 10; m_plo[i] = 5; m_pv[i] = 1'b0; m_en_last[i] = 1'b0;
         end
      end else begin
         m_err = we && !ok;
         for (int i = 0; i < 4; i++) begin
            w = we && ok && (ch == i);
            m_en_last[i] = en[i];
            if (!en[i]) begin
               m_cnt[i] = 0;
               if (w) begin m_div[i] = dv; m_lo[i] = lo; m_pv[i] = 1'b0; end
            end else if (m_cnt[i] == m_div[i] - 1) begin
               m_cnt[i] = 0;
               if (w) begin
                  m_div[i] = dv; m_lo[i] = lo; m_pv[i] = 1'b0;
               end else if (m_pv[i]) begin
                  m_div[i] = m_pdiv[i]; m_lo[i] = m_plo[i]; m_pv[i] = 1'b0;
               end
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
               if (w) begin m_pdiv[i] = dv; m_plo[i] = lo; m_pv[i] = 1'b1; end
            end
         end
      end
      #1;
   endtask

   task automatic cfg_write(input int ch, input int dv, input int lo);
      bus.cfg_ch  = 4'(ch);
      bus.cfg_div = 8'(dv);
      bus.cfg_lo  = 8'(lo);
      bus.cfg_we  = 1'b1;
      step();
      bus.cfg_we  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.ch_en = 4'b0001;
      bus.cfg_we = 1'b0;
      step();
      step();
      checks++;
      if (bus.clk_out !== 4'b0000) begin
         errors++; $display("FAIL reset_clk_out: got %b, expected 0000", bus.clk_out);
      end
      checks++;
      if (bus.tick !== 4'b0000) begin
         errors++; $display("FAIL reset_tick: got %b, expected 0000", bus.tick);
      end
      checks++;
      if (bus.cfg_err !== 1'b0) begin
         errors++; $display("FAIL reset_cfg_err: got %b, expected 0", bus.cfg_err);
      end
      $display("test_reset done: clk_out=%b tick=%b cfg_err=%b", bus.clk_out, bus.tick, bus.cfg_err);
   endtask

   task automatic test_basic();
      logic [3:0] ec, et;
      rst = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         ec = ((k % 10) >= 5) ? 4'b0001 : 4'b0000;
         et = ((k % 10) == 0) ? 4'b0001 : 4'b0000;
         checks++;
         if (bus.clk_out !== ec || bus.tick !== et) begin
            errors++;
            $display("FAIL basic_cycle%0d: clk_out=%b tick=%b, expected %b %b", k, bus.clk_out, bus.tick, ec, et);
         end
      end
      $display("test_basic done: 40 cycles of 5 low / 5 high on ch0");
   endtask

   task automatic test_div_change();
      logic ec, et;
      int p, c;
      for (int k = 0; k < 3; k++) step();
      cfg_write(0, 4, 1);
      for (int j = 1; j <= 20; j++) begin
         if (j > 1) step();
         if (j <= 6) begin
            c = 3 + j; ec = (c >= 5); et = 1'b0;
         end else begin
            p = (j - 7) % 4; ec = (p >= 1); et = (p == 0);
         end
         checks++;
         if (bus.clk_out[0] !== ec || bus.tick[0] !== et || bus.clk_out !== exp_clk()) begin
            errors++;
            $display("FAIL div_change_j%0d: clk_out=%b tick=%b, expected ch0 clk=%b tick=%b model=%b",
                     j, bus.clk_out, bus.tick, ec, et, exp_clk());
         end
      end
      $display("test_div_change done: ch0 switched to 1 low / 3 high after its period");
   endtask

   task automatic test_wrap_write();
      int p;
      bus.ch_en = 4'b0011;
      for (int k = 0; k < 9; k++) step();
      cfg_write(1, 6, 2);
      for (int j = 1; j <= 12; j++) begin
         if (j > 1) step();
         p = (j - 1) % 6;
         checks++;
         if (bus.clk_out[1] !== (p >= 2) || bus.tick[1] !== (p == 0)) begin
            errors++;
            $display("FAIL wrap_write_j%0d: clk1=%b tick1=%b, expected %b %b", j, bus.clk_out[1], bus.tick[1], p >= 2, p == 0);
         end
      end
      step();
      cfg_write(1, 3, 1);
      cfg_write(1, 5, 3);
      for (int k = 0; k < 4; k++) step();
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         p = k % 5;
         checks++;
         if (bus.clk_out[1] !== (p >= 3) || bus.tick[1] !== (p == 0) || bus.clk_out !== exp_clk()) begin
            errors++;
            $display("FAIL last_write_wins_k%0d: clk_out=%b tick1=%b, expected clk1=%b tick1=%b model=%b",
                     k, bus.clk_out, bus.tick[1], p >= 3, p == 0, exp_clk());
         end
      end
      $display("test_wrap_write done: wrap-cycle write and last-write-wins on ch1");
   endtask

   task automatic test_cfg_err();
      int bch[3] = '{5, 0, 1};
      int bdv[3] = '{4, 1, 6};
      int blo[3] = '{2, 1, 6};
      for (int b = 0; b < 3; b++) begin
         cfg_write(bch[b], bdv[b], blo[b]);
         checks++;
         if (bus.cfg_err !== 1'b1 || bus.clk_out !== exp_clk() || bus.tick !== exp_tick()) begin
            errors++;
            $display("FAIL cfg_err_pulse%0d: cfg_err=%b clk_out=%b tick=%b, expected 1 %b %b",
                     b, bus.cfg_err, bus.clk_out, bus.tick, exp_clk(), exp_tick());
         end
         step();
         checks++;
         if (bus.cfg_err !== 1'b0) begin
            errors++; $display("FAIL cfg_err_clear%0d: cfg_err=%b, expected 0", b, bus.cfg_err);
         end
      end
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if (bus.clk_out !== exp_clk() || bus.tick !== exp_tick()) begin
            errors++;
            $display("FAIL cfg_err_periods%0d: clk_out=%b tick=%b, expected %b %b", k, bus.clk_out, bus.tick, exp_clk(), exp_tick());
         end
      end
      $display("test_cfg_err done: three rejected writes");
   endtask

   task automatic test_disable();
      int found;
      bus.ch_en = 4'b0111;
      for (int k = 0; k < 7; k++) step();
      checks++;
      if (bus.clk_out[2] !== 1'b1) begin
         errors++; $display("FAIL disable_pre_high: clk2=%b, expected 1", bus.clk_out[2]);
      end
      bus.ch_en[2] = 1'b0;
      step();
      checks++;
      if (bus.clk_out[2] !== 1'b0 || bus.tick[2] !== 1'b0 || bus.clk_out !== exp_clk()) begin
         errors++;
         $display("FAIL disable_hold: clk_out=%b tick2=%b, expected clk2=0 tick2=0 model=%b", bus.clk_out, bus.tick[2], exp_clk());
      end
      for (int k = 0; k < 3; k++) step();
      bus.ch_en[2] = 1'b1;
      found = 0;
      for (int n = 1; n <= 20 && found == 0; n++) begin
         step();
         if (bus.tick[2] === 1'b1) found = n;
      end
      checks++;
      if (found !== 10) begin
         errors++; $display("FAIL reenable_first_tick: after %0d cycles, expected 10 (0 = none)", found);
      end
      $display("test_disable done: ch2 first tick %0d cycles after re-enable", found);
   endtask

   task automatic test_reset_mid();
      logic [3:0] ec, et;
      bus.ch_en = 4'b1111;
      step();
      step();
      cfg_write(3, 4, 2);
      step();
      rst = 1'b0;
      bus.cfg_ch = 4'd5;
      bus.cfg_we = 1'b1;
      step();
      bus.cfg_we = 1'b0;
      checks++;
      if (bus.clk_out !== 4'b0000 || bus.tick !== 4'b0000 || bus.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: clk_out=%b tick=%b cfg_err=%b, expected 0000 0000 0",
                  bus.clk_out, bus.tick, bus.cfg_err);
      end
      rst = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         ec = ((k % 10) >= 5) ? 4'b1111 : 4'b0000;
         et = ((k % 10) == 0) ? 4'b1111 : 4'b0000;
         checks++;
         if (bus.clk_out !== ec || bus.tick !== et) begin
            errors++;
            $display("FAIL reset_mid_cycle%0d: clk_out=%b tick=%b, expected %b %b", k, bus.clk_out, bus.tick, ec, et);
         end
      end
      $display("test_reset_mid done: all channels back to 10-cycle periods");
   endtask

   task automatic test_random();
      int bad = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 39) == 0) bus.ch_en = 4'($urandom_range(0, 15));
         bus.cfg_we  = ($urandom_range(0, 3) == 0);
         bus.cfg_ch  = 4'($urandom_range(0, 5));
         bus.cfg_div = 8'($urandom_range(0, 12));
         bus.cfg_lo  = 8'($urandom_range(0, 12));
         rst = ($urandom_range(0, 199) != 0);
         step();
         checks++;
         if (bus.clk_out !== exp_clk() || bus.tick !== exp_tick() || bus.cfg_err !== m_err) begin
            errors++; bad++;
            if (bad <= 10)
               $display("FAIL random_cycle%0d: clk_out=%b tick=%b cfg_err=%b, expected %b %b %b",
                        k, bus.clk_out, bus.tick, bus.cfg_err, exp_clk(), exp_tick(), m_err);
         end
      end
      bus.cfg_we = 1'b0;
      rst = 1'b1;
      $display("test_random done: 3000 randomized cycles");
   endtask

   initial begin
      rst = 1'b0;
      bus.ch_en = '0;
      bus.cfg_we = 1'b0;
      bus.cfg_ch = '0;
      bus.cfg_div = '0;
      bus.cfg_lo = '0;
      test_reset();
      test_basic();
      test_div_change();
      test_wrap_write();
      test_cfg_err();
      test_disable();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
